// File: rtl/io_evt_pkg.sv
// Shared event definitions for the board I/O path: event kinds and index-width helper,
// reused by the button reader and by LED/pattern consumers.
package io_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_LONG    = 2'b10
    } evt_kind_t;

    localparam int EVT_KIND_W = 2;

    // A one-channel build still needs a 1-bit index field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_event_reader_if.sv
// Valid/ready event stream from the button reader plus its sticky overflow flag and clear.
interface btn_event_reader_if #(
    parameter int NUM_BTNS = 4
);
    import io_evt_pkg::*;

    localparam int IDX_W = idx_width(NUM_BTNS);

    logic             evt_valid;
    logic             evt_ready;
    evt_kind_t        evt_kind;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_overflow;
    logic             ovf_clr;

    modport master (
        output evt_valid, evt_kind, evt_idx, evt_overflow,
        input  evt_ready, ovf_clr
    );

    modport slave (
        input  evt_valid, evt_kind, evt_idx, evt_overflow,
        output evt_ready, ovf_clr
    );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: polarity fix, 2-FF synchroniser, debounce and optional hold counter.
// Long-press detection is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_ch #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int ACTIVE_LOW        = 1,
    parameter int LONG_PRESS_CYCLES = 12000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_long
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             w_raw;
    logic             w_differ;
    logic             w_accept;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    assign w_raw    = i_pin ^ (ACTIVE_LOW != 0);
    assign w_differ = (r_sync2 != r_stable);
    assign w_accept = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Any sample agreeing with the stable level restarts the qualification window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = w_accept && r_sync2;
    assign o_fall  = w_accept && !r_sync2;

`ifdef BTN_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    logic [HOLD_W-1:0] r_hold;

    // Counter parks one past the trigger value so a long hold reports only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (!r_stable) begin
            r_hold <= '0;
        end else if (r_hold != HOLD_W'(LONG_PRESS_CYCLES)) begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end

    assign o_long = r_stable && !w_accept && (r_hold == HOLD_W'(LONG_PRESS_CYCLES - 1));
`else
    logic w_unused_long_cfg;

    assign w_unused_long_cfg = (LONG_PRESS_CYCLES > 0);
    assign o_long            = 1'b0;
`endif

endmodule

// File: rtl/btn_event_reader.sv
// Button pins to press/release(/long-press) event stream with per-channel pending slots.
// Optional long-press events are enabled by defining BTN_LONG_PRESS_EN.
module btn_event_reader
    import io_evt_pkg::*;
#(
    parameter int NUM_BTNS          = 4,
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int ACTIVE_LOW        = 1,
    parameter int LONG_PRESS_CYCLES = 12000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] i_btn_pin,
    output logic [NUM_BTNS-1:0] o_btn_level,
    btn_event_reader_if.master  evt
);

    localparam int IDX_W = idx_width(NUM_BTNS);

    logic [NUM_BTNS-1:0] w_rise;
    logic [NUM_BTNS-1:0] w_fall;
    logic [NUM_BTNS-1:0] w_long;
    logic [NUM_BTNS-1:0] w_evt;
    logic [NUM_BTNS-1:0] w_drain;
    evt_kind_t           w_new_kind [NUM_BTNS];
    logic [IDX_W-1:0]    w_sel;
    logic                w_any;
    logic                w_load;
    logic                w_ovf_set;

    logic [NUM_BTNS-1:0] r_pend;
    evt_kind_t           r_kind [NUM_BTNS];
    logic                r_valid;
    evt_kind_t           r_out_kind;
    logic [IDX_W-1:0]    r_out_idx;
    logic                r_ovf;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .ACTIVE_LOW       (ACTIVE_LOW),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_pin  (i_btn_pin[g]),
            .o_level(o_btn_level[g]),
            .o_rise (w_rise[g]),
            .o_fall (w_fall[g]),
            .o_long (w_long[g])
        );
    end

    assign w_evt = w_rise | w_fall | w_long;

    // Scanning downwards leaves the lowest pending index as the winner.
    always_comb begin
        w_any   = 1'b0;
        w_sel   = '0;
        w_drain = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            w_new_kind[i] = w_fall[i] ? EVT_RELEASE : (w_rise[i] ? EVT_PRESS : EVT_LONG);
        end
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_any = 1'b1;
                w_sel = IDX_W'(i);
            end
        end
        w_load = (!r_valid || evt.evt_ready) && w_any;
        for (int i = 0; i < NUM_BTNS; i++) begin
            w_drain[i] = w_load && (w_sel == IDX_W'(i));
        end
        w_ovf_set = |(w_evt & r_pend & ~w_drain);
    end

    // A new edge always wins the slot; draining only clears it when no edge arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            for (int i = 0; i < NUM_BTNS; i++) begin
                r_kind[i] <= EVT_PRESS;
            end
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (w_evt[i]) begin
                    r_pend[i] <= 1'b1;
                    r_kind[i] <= w_new_kind[i];
                end else if (w_drain[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_out_kind <= EVT_PRESS;
            r_out_idx  <= '0;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_out_kind <= r_kind[w_sel];
            r_out_idx  <= w_sel;
        end else if (evt.evt_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (evt.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign evt.evt_valid    = r_valid;
    assign evt.evt_kind     = r_out_kind;
    assign evt.evt_idx      = r_out_idx;
    assign evt.evt_overflow = r_ovf;

endmodule
